// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the PISO transmitter and its matching receiver.
// The build option PISO_LSB_FIRST_EN (used by piso_shift_tx) selects LSB-first bit order.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_W = 8;

  // Counter width for DATA_W bit positions; never below one bit.
  function automatic int cnt_w(input int data_w);
    return (data_w <= 2) ? 1 : $clog2(data_w);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit position counter for one transmitted word: runs 0..DATA_W-1 and saturates there.
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = cnt_w(DATA_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             at_last
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  assign at_last = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !at_last) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter with valid/ready input and back-to-back streaming.
// Define PISO_LSB_FIRST_EN to send LSB first (right shift); default is MSB first.
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_q,
  output logic              o_bit_valid,
  output logic              o_first,
  output logic              o_last,
  output logic              o_busy
);

  localparam int CNT_W = cnt_w(DATA_W);

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              at_last;
  logic              shifting;
  logic              last_bit;
  logic              accept;

  assign shifting = (state == SHIFT);
  assign last_bit = shifting && at_last;
  assign o_ready  = !i_rst && (!shifting || at_last);
  assign accept   = i_valid && o_ready;

  piso_bit_cnt #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk    (i_clk),
    .rst    (i_rst),
    .clear  (accept || last_bit),
    .en     (shifting),
    .count  (bit_cnt),
    .at_last(at_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SHIFT;
      SHIFT:   if (at_last && !accept) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A reload on the last bit overrides that bit's shift so words abut with no gap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= i_data;
    end else if (shifting) begin
`ifdef PISO_LSB_FIRST_EN
      shreg <= {1'b0, shreg[DATA_W-1:1]};
`else
      shreg <= {shreg[DATA_W-2:0], 1'b0};
`endif
    end
  end

`ifdef PISO_LSB_FIRST_EN
  assign o_q = shifting && shreg[0];
`else
  assign o_q = shifting && shreg[DATA_W-1];
`endif

  assign o_bit_valid = shifting;
  assign o_busy      = shifting;
  assign o_first     = shifting && (bit_cnt == '0);
  assign o_last      = last_bit;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: a queue-of-bits model compared every cycle,
// plus literal expectations for the directed scenarios (both bit-order builds).
module tb_piso_shift_tx;

  localparam int W = 8;

`ifdef PISO_LSB_FIRST_EN
  localparam logic [7:0]  SEQ_A5      = 8'hA5;
  localparam logic [15:0] SEQ_0F_F0   = 16'hF00F;
  localparam logic [15:0] SEQ_0F_55   = 16'hF0AA;
  localparam logic [7:0]  SEQ_81      = 8'h81;
`else
  localparam logic [7:0]  SEQ_A5      = 8'hA5;
  localparam logic [15:0] SEQ_0F_F0   = 16'h0FF0;
  localparam logic [15:0] SEQ_0F_55   = 16'h0F55;
  localparam logic [7:0]  SEQ_81      = 8'h81;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  logic         q_out;
  logic         bit_valid;
  logic         first;
  logic         last;
  logic         busy;

  int assert_count = 0;
  int fail_count   = 0;
  logic check_en   = 1'b0;

  typedef struct packed {
    logic b;
    logic is_first;
    logic is_last;
  } tx_bit_t;

  tx_bit_t model_q[$];

  logic [31:0] cap_bits;
  logic [31:0] cap_first;
  logic [31:0] cap_last;
  int          cap_count;

  piso_shift_tx #(.DATA_W(W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_data     (data),
    .i_valid    (valid),
    .o_ready    (ready),
    .o_q        (q_out),
    .o_bit_valid(bit_valid),
    .o_first    (first),
    .o_last     (last),
    .o_busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic model_ready();
    return !rst && (model_q.size() <= 1);
  endfunction

  // Model: every accepted word becomes W queued bits; one bit leaves per clock.
  always @(posedge clk) begin : model_update
    logic    acc;
    tx_bit_t e;
    if (rst) begin
      model_q.delete();
    end else begin
      acc = valid && (model_q.size() <= 1);
      if (model_q.size() > 0) void'(model_q.pop_front());
      if (acc) begin
        for (int i = 0; i < W; i++) begin
`ifdef PISO_LSB_FIRST_EN
          e.b = data[i];
`else
          e.b = data[W-1-i];
`endif
          e.is_first = (i == 0);
          e.is_last  = (i == W - 1);
          model_q.push_back(e);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    tx_bit_t e;
    if (check_en) begin
      e = '0;
      if (model_q.size() > 0) e = model_q[0];
      checkOutput("o_q",         32'(q_out),     32'(e.b));
      checkOutput("o_bit_valid", 32'(bit_valid), 32'(model_q.size() > 0));
      checkOutput("o_busy",      32'(busy),      32'(model_q.size() > 0));
      checkOutput("o_first",     32'(first),     32'(e.is_first));
      checkOutput("o_last",      32'(last),      32'(e.is_last));
      checkOutput("o_ready",     32'(ready),     32'(model_ready()));
    end
  end

  always @(negedge clk) begin : capture
    if (bit_valid) begin
      cap_bits  = {cap_bits[30:0], q_out};
      cap_first = {cap_first[30:0], first};
      cap_last  = {cap_last[30:0], last};
      cap_count++;
    end
  end

  task automatic clearCapture();
    cap_bits  = '0;
    cap_first = '0;
    cap_last  = '0;
    cap_count = 0;
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [W-1:0] d);
    rst   = r;
    valid = v;
    data  = d;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench one tick after the accepting edge, i.e. in the word's first-bit cycle.
  task automatic sendWord(input logic [W-1:0] d, input logic drop, output int waits);
    logic rdy;
    logic accepted;
    applyStimulus(1'b0, 1'b1, d);
    waits    = 0;
    accepted = 1'b0;
    for (int n = 0; n < 40 && !accepted; n++) begin
      rdy = model_ready();
      @(posedge clk);
      #1;
      if (rdy) accepted = 1'b1;
      else     waits++;
    end
    checkOutput("accept_timeout", 32'(accepted), 32'd1);
    if (drop) valid = 1'b0;
  endtask

  initial begin
    int waits;
    applyStimulus(1'b1, 1'b1, 8'h3C);
    clearCapture();
    @(posedge clk);
    #1;
    check_en = 1'b1;

    // Reset held three edges with a word offered: nothing may be accepted.
    stepCycles(2);
    checkOutput("reset_ready", 32'(ready), 32'd0);
    checkOutput("reset_bit_valid", 32'(bit_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    #1;
    checkOutput("ready_after_release", 32'(ready), 32'd1);
    stepCycles(1);

    // Single word
    $display("[TB] single word 0xA5");
    clearCapture();
    sendWord(8'hA5, 1'b1, waits);
    checkOutput("a5_wait", 32'(waits), 32'd0);
    stepCycles(10);
    checkOutput("a5_count", 32'(cap_count), 32'd8);
    checkOutput("a5_bits",  32'(cap_bits[7:0]),  32'(SEQ_A5));
    checkOutput("a5_first", 32'(cap_first[7:0]), 32'h80);
    checkOutput("a5_last",  32'(cap_last[7:0]),  32'h01);
    checkOutput("a5_idle_q", 32'(q_out), 32'd0);

    // Back-to-back with valid held
    $display("[TB] back-to-back 0x0F, 0xF0");
    clearCapture();
    sendWord(8'h0F, 1'b0, waits);
    sendWord(8'hF0, 1'b1, waits);
    checkOutput("b2b_wait", 32'(waits), 32'd7);
    stepCycles(10);
    checkOutput("b2b_count", 32'(cap_count), 32'd16);
    checkOutput("b2b_bits",  32'(cap_bits[15:0]),  32'(SEQ_0F_F0));
    checkOutput("b2b_first", 32'(cap_first[15:0]), 32'h8080);
    checkOutput("b2b_last",  32'(cap_last[15:0]),  32'h0101);

    // Word offered mid-frame waits for the last bit
    $display("[TB] mid-frame offer of 0x55");
    clearCapture();
    sendWord(8'h0F, 1'b1, waits);
    stepCycles(1);
    sendWord(8'h55, 1'b1, waits);
    checkOutput("ignore_wait", 32'(waits), 32'd6);
    stepCycles(10);
    checkOutput("ignore_count", 32'(cap_count), 32'd16);
    checkOutput("ignore_bits",  32'(cap_bits[15:0]), 32'(SEQ_0F_55));

    // Reset during bit 3 aborts the frame
    $display("[TB] reset mid-frame");
    sendWord(8'hFF, 1'b1, waits);
    stepCycles(2);
    applyStimulus(1'b1, 1'b1, 8'h81);
    stepCycles(1);
    checkOutput("abort_q",         32'(q_out),     32'd0);
    checkOutput("abort_bit_valid", 32'(bit_valid), 32'd0);
    checkOutput("abort_ready",     32'(ready),     32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    clearCapture();
    sendWord(8'h81, 1'b1, waits);
    stepCycles(10);
    checkOutput("after_abort_count", 32'(cap_count), 32'd8);
    checkOutput("after_abort_bits",  32'(cap_bits[7:0]),  32'(SEQ_81));
    checkOutput("after_abort_first", 32'(cap_first[7:0]), 32'h80);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/piso_shift_tx.md
# piso_shift_tx

Parallel-in serial-out shift transmitter: accepts a DATA_W-bit word over a valid/ready handshake and drives it out one bit per clock on a serial line. It is the transmit end of the serial-in shift-register receiver. Bits go MSB first by default, so a left-shifting receiver sampling o_q on every o_bit_valid cycle reassembles the word after DATA_W cycles. Back-to-back words stream with no idle gap.

## Interface
- DATA_W, 8, word width in bits; must be ≥ 2.
- i_clk  input  1  single clock; all logic on the rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_data  input  DATA_W  parallel word to send; sampled only on handshake.
- i_valid  input  1  i_data is valid.
- o_ready  output  1  transmitter can accept a word this cycle.
- o_q  output  1  serial data bit.
- o_bit_valid  output  1  o_q carries a frame bit this cycle.
- o_first  output  1  current bit is the first bit of a word.
- o_last  output  1  current bit is the last bit of a word.
- o_busy  output  1  a frame is in progress (same as o_bit_valid).

## Operation
- States: IDLE and SHIFT.
- Handshake: a word is accepted on a rising edge where i_valid && o_ready.
- o_ready = !i_rst && (state == IDLE || (state == SHIFT && bit_cnt == DATA_W-1)).
- On accept: load the shift register with i_data, set bit_cnt = 0, go to SHIFT.
- In SHIFT, each cycle:
  - o_q = shreg[DATA_W-1].
  - Shift left on each edge, filling 0.
  - bit_cnt increments.
- When bit_cnt == DATA_W-1:
  - Accept in the same cycle: reload, bit_cnt = 0, stay in SHIFT.
  - No accept: go to IDLE.
- i_valid while o_ready = 0 is ignored. The source must hold i_data and i_valid until accepted.
- o_first = SHIFT && bit_cnt == 0. o_last = SHIFT && bit_cnt == DATA_W-1.
- bit_cnt width is $clog2(DATA_W). It never exceeds DATA_W-1; no wrap beyond that.
- In IDLE: o_q = 0, o_bit_valid = 0, o_first = 0, o_last = 0.

## Timing
- Reset values: state IDLE, shreg 0, bit_cnt 0. o_q, o_bit_valid, o_first, o_last and o_busy are 0. o_ready is 0 while i_rst = 1.
- o_ready goes to 1 in the first cycle after i_rst deasserts.
- Latency: word accepted at edge N → its first bit on o_q during cycle N+1 (after edge N) → its last bit during cycle N+DATA_W.
- Throughput: one word per DATA_W cycles under continuous i_valid, with o_bit_valid held high throughout.
- Reset mid-frame: the frame is aborted. All outputs return to reset values after the reset edge, with no partial completion. The next accepted word starts with o_first.
- Reset and handshake in the same cycle: reset wins and the word is not accepted (o_ready is already 0).

## Configuration
- PISO_LSB_FIRST_EN defined:
  - o_q = shreg[0], and the register shifts right, filling 0.
  - The word goes out LSB first, for a right-shifting receiver.
- Not defined: MSB first, as above.
- Handshake, counters, flags and timing are identical in both builds.

## Structure
- Shared package piso_pkg:
  - state typedef (IDLE, SHIFT);
  - default DATA_W constant;
  - CNT_W = $clog2(DATA_W) function/constant, shared with the receiver side.
- One sub-module is natural: piso_bit_cnt.
  - Inputs: clear/load, enable.
  - Outputs: count, at_last.
  - FSM, shift register and handshake stay in piso_shift_tx.

## Test plan
- Reset: hold i_rst 3 cycles with i_valid = 1 → o_ready = 0 and o_bit_valid = 0 throughout. o_ready = 1 in the first cycle after release.
- Single word 0xA5 (MSB first) → o_q = 1,0,1,0,0,1,0,1 over 8 consecutive cycles. o_first on bit 1, o_last on bit 8, then IDLE with o_q = 0.
- Back-to-back 0x0F then 0xF0, i_valid held → 16 contiguous valid bits 0000111111110000. o_ready high only on the o_last cycle after the first accept.
- i_valid asserted with 0x55 during bits 2–7 of a 0x0F frame → ignored. The frame is unchanged, and 0x55 is accepted only on the o_last cycle.
- Reset asserted on bit 3 of 0xFF → the next cycle has o_q = 0 and o_bit_valid = 0. A following 0x81 yields 1,0,0,0,0,0,0,1 starting with o_first.
- PISO_LSB_FIRST_EN build, word 0x0F → o_q = 1,1,1,1,0,0,0,0. A loopback into a right-shifting receiver yields 0x0F after 8 cycles.
